// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields and forwarding taps in, ALU operands and registered controls out.
// The master drives ID/forwarding inputs; the slave is the ID/EX register. bubble_cnt_o exists with ID_EX_BUBBLE_CNT_EN.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   rs1_data_i;
    logic [XLEN-1:0]   rs2_data_i;
    logic [XLEN-1:0]   imm_i;
    logic [REG_AW-1:0] rs1_addr_i;
    logic [REG_AW-1:0] rs2_addr_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic [3:0]        alu_op_i;
    logic [1:0]        op1_sel_i;
    logic              op2_sel_i;
    logic              reg_write_i;
    logic              mem_read_i;
    logic              mem_write_i;
    logic [REG_AW-1:0] exmem_rd_i;
    logic              exmem_reg_write_i;
    logic [XLEN-1:0]   exmem_result_i;
    logic [REG_AW-1:0] memwb_rd_i;
    logic              memwb_reg_write_i;
    logic [XLEN-1:0]   memwb_result_i;
    logic              ex_valid_o;
    logic [XLEN-1:0]   op1_o;
    logic [XLEN-1:0]   op2_o;
    logic [3:0]        alu_op_o;
    logic [XLEN-1:0]   store_data_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              reg_write_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic              load_use_o;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0]       bubble_cnt_o;
`endif

    modport master (
        output stall_i, flush_i, valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, alu_op_i, op1_sel_i, op2_sel_i,
               reg_write_i, mem_read_i, mem_write_i,
               exmem_rd_i, exmem_reg_write_i, exmem_result_i,
               memwb_rd_i, memwb_reg_write_i, memwb_result_i,
        input  ex_valid_o, op1_o, op2_o, alu_op_o, store_data_o, rd_addr_o,
               reg_write_o, mem_read_o, mem_write_o, load_use_o
`ifdef ID_EX_BUBBLE_CNT_EN
        , input bubble_cnt_o
`endif
    );

    modport slave (
        input  stall_i, flush_i, valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, alu_op_i, op1_sel_i, op2_sel_i,
               reg_write_i, mem_read_i, mem_write_i,
               exmem_rd_i, exmem_reg_write_i, exmem_result_i,
               memwb_rd_i, memwb_reg_write_i, memwb_result_i,
        output ex_valid_o, op1_o, op2_o, alu_op_o, store_data_o, rd_addr_o,
               reg_write_o, mem_read_o, mem_write_o, load_use_o
`ifdef ID_EX_BUBBLE_CNT_EN
        , output bubble_cnt_o
`endif
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
// Latency: 1 cycle ID->registered fields; operands/forwarding and load_use_o are combinational.
// Backpressure: stall_i holds, flush_i or a load-use loads a bubble. Optional bubble counter: ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic           clk_i,
    input logic           rst_i,
    id_ex_stage_if.slave  bus
);
    logic              valid_q;
    logic [XLEN-1:0]   pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic [3:0]        alu_op_q;
    logic [1:0]        op1_sel_q;
    logic              op2_sel_q, reg_write_q, mem_read_q, mem_write_q;

    logic              rs1_used, rs2_used, load_use, load_bubble;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf_data,
        input logic              em_we,
        input logic [REG_AW-1:0] em_rd,
        input logic [XLEN-1:0]   em_res,
        input logic              mw_we,
        input logic [REG_AW-1:0] mw_rd,
        input logic [XLEN-1:0]   mw_res
    );
        // x0 is hardwired; EX/MEM is younger than MEM/WB so it wins.
        if (rs == '0)                  return rf_data;
        else if (em_we && em_rd == rs) return em_res;
        else if (mw_we && mw_rd == rs) return mw_res;
        else                           return rf_data;
    endfunction

    always_comb begin
        rs1_used    = (bus.op1_sel_i == 2'b00);
        rs2_used    = !bus.op2_sel_i || bus.mem_write_i;
        load_use    = valid_q && mem_read_q && (rd_q != '0) && bus.valid_i &&
                      ((rs1_used && rd_q == bus.rs1_addr_i) ||
                       (rs2_used && rd_q == bus.rs2_addr_i));
        load_bubble = bus.flush_i || (!bus.stall_i && load_use);
        fwd_rs1     = fwd_sel(rs1_q, rs1_data_q, bus.exmem_reg_write_i, bus.exmem_rd_i,
                              bus.exmem_result_i, bus.memwb_reg_write_i, bus.memwb_rd_i,
                              bus.memwb_result_i);
        fwd_rs2     = fwd_sel(rs2_q, rs2_data_q, bus.exmem_reg_write_i, bus.exmem_rd_i,
                              bus.exmem_result_i, bus.memwb_reg_write_i, bus.memwb_rd_i,
                              bus.memwb_result_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || load_bubble) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_op_q    <= '0;
            op1_sel_q   <= '0;
            op2_sel_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!bus.stall_i) begin
            // An empty ID slot captures its data but carries no side effects.
            valid_q     <= bus.valid_i;
            pc_q        <= bus.pc_i;
            rs1_data_q  <= bus.rs1_data_i;
            rs2_data_q  <= bus.rs2_data_i;
            imm_q       <= bus.imm_i;
            rs1_q       <= bus.rs1_addr_i;
            rs2_q       <= bus.rs2_addr_i;
            rd_q        <= bus.valid_i ? bus.rd_addr_i : '0;
            alu_op_q    <= bus.valid_i ? bus.alu_op_i : 4'b0000;
            op1_sel_q   <= bus.op1_sel_i;
            op2_sel_q   <= bus.op2_sel_i;
            reg_write_q <= bus.valid_i && bus.reg_write_i;
            mem_read_q  <= bus.valid_i && bus.mem_read_i;
            mem_write_q <= bus.valid_i && bus.mem_write_i;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            bubble_cnt_q <= '0;
        else if (load_bubble || (!bus.stall_i && !bus.valid_i))
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end

    assign bus.bubble_cnt_o = bubble_cnt_q;
`endif

    always_comb begin
        unique case (op1_sel_q)
            2'b00:   bus.op1_o = fwd_rs1;
            2'b01:   bus.op1_o = pc_q;
            default: bus.op1_o = '0;
        endcase
    end

    assign bus.op2_o        = op2_sel_q ? imm_q : fwd_rs2;
    assign bus.store_data_o = fwd_rs2;
    assign bus.ex_valid_o   = valid_q;
    assign bus.alu_op_o     = alu_op_q;
    assign bus.rd_addr_o    = rd_q;
    assign bus.reg_write_o  = reg_write_q;
    assign bus.mem_read_o   = mem_read_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.load_use_o   = load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each cycle's outputs, a monitor compares.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();
    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic [1:0]  op1_sel;
        logic        op2_sel, rw, mr, mw;
        logic [4:0]  em_rd;  logic em_we; logic [31:0] em_res;
        logic [4:0]  mw_rd;  logic mw_we; logic [31:0] mw_res;
    } stim_t;

    // Contents of the EX slot as the model sees it; strict marks a bubble that must show alu_op=0, rd=0.
    typedef struct {
        logic        valid, strict;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic [1:0]  op1_sel;
        logic        op2_sel, rw, mr, mw;
    } ex_t;

    typedef struct {
        logic        valid, strict, rw, mr, mw, lu;
        logic [31:0] op1, op2, sd, cnt;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exq[$];
    ex_t         ex_m;
    logic [31:0] cnt_m;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        last_lu = 1'b0;

    function automatic ex_t bubble();
        ex_t b = '{default: '0};
        b.strict = 1'b1;
        return b;
    endfunction

    function automatic stim_t idle();
        stim_t s = '{default: '0};
        return s;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf, input stim_t s);
        if (rs == 5'd0) return rf;
        if (s.em_we && s.em_rd == rs) return s.em_res;
        if (s.mw_we && s.mw_rd == rs) return s.mw_res;
        return rf;
    endfunction

    function automatic logic hazard(input stim_t s);
        logic needs1 = (s.op1_sel == 2'b00) && (s.rs1 == ex_m.rd);
        logic needs2 = (!s.op2_sel || s.mw) && (s.rs2 == ex_m.rd);
        return ex_m.valid && ex_m.mr && ex_m.rd != 5'd0 && s.valid && (needs1 || needs2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        logic [31:0] f1, f2;
        @(negedge clk);
        rst = s.rst;
        bus.stall_i = s.stall;  bus.flush_i = s.flush;  bus.valid_i = s.valid;
        bus.pc_i = s.pc;  bus.rs1_data_i = s.rs1d;  bus.rs2_data_i = s.rs2d;  bus.imm_i = s.imm;
        bus.rs1_addr_i = s.rs1;  bus.rs2_addr_i = s.rs2;  bus.rd_addr_i = s.rd;
        bus.alu_op_i = s.alu_op;  bus.op1_sel_i = s.op1_sel;  bus.op2_sel_i = s.op2_sel;
        bus.reg_write_i = s.rw;  bus.mem_read_i = s.mr;  bus.mem_write_i = s.mw;
        bus.exmem_rd_i = s.em_rd;  bus.exmem_reg_write_i = s.em_we;  bus.exmem_result_i = s.em_res;
        bus.memwb_rd_i = s.mw_rd;  bus.memwb_reg_write_i = s.mw_we;  bus.memwb_result_i = s.mw_res;

        f1 = operand(ex_m.rs1, ex_m.rs1d, s);
        f2 = operand(ex_m.rs2, ex_m.rs2d, s);
        e.valid  = ex_m.valid;  e.strict = ex_m.strict;
        e.rw = ex_m.rw;  e.mr = ex_m.mr;  e.mw = ex_m.mw;
        e.alu_op = ex_m.alu_op;  e.rd = ex_m.rd;
        e.op1 = (ex_m.op1_sel == 2'b00) ? f1 : (ex_m.op1_sel == 2'b01) ? ex_m.pc : 32'd0;
        e.op2 = ex_m.op2_sel ? ex_m.imm : f2;
        e.sd  = f2;
        e.lu  = hazard(s);
        e.cnt = cnt_m;
        exq.push_back(e);
        last_lu = e.lu;

        if (s.rst) cnt_m = 32'd0;
        else if (s.flush || (!s.stall && (e.lu || !s.valid))) cnt_m = cnt_m + 32'd1;

        if (s.rst || s.flush || (!s.stall && e.lu)) ex_m = bubble();
        else if (!s.stall) begin
            if (!s.valid) begin
                ex_m = bubble();
                ex_m.strict = 1'b0;
            end else begin
                ex_m = '{valid: 1'b1, strict: 1'b0, pc: s.pc, rs1d: s.rs1d, rs2d: s.rs2d,
                         imm: s.imm, rs1: s.rs1, rs2: s.rs2, rd: s.rd, alu_op: s.alu_op,
                         op1_sel: s.op1_sel, op2_sel: s.op2_sel, rw: s.rw, mr: s.mr, mw: s.mw};
            end
        end
    endtask

    // Monitor: one DUT output set per cycle, sampled mid-low-phase after stimulus settles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exq.size() > 0) begin
                e = exq.pop_front();
                chk("ex_valid", 32'(bus.ex_valid_o), 32'(e.valid));
                chk("reg_write", 32'(bus.reg_write_o), 32'(e.rw));
                chk("mem_read", 32'(bus.mem_read_o), 32'(e.mr));
                chk("mem_write", 32'(bus.mem_write_o), 32'(e.mw));
                chk("load_use", 32'(bus.load_use_o), 32'(e.lu));
                if (e.valid || e.strict) begin
                    chk("alu_op", 32'(bus.alu_op_o), 32'(e.alu_op));
                    chk("rd_addr", 32'(bus.rd_addr_o), 32'(e.rd));
                end
                if (e.valid) begin
                    chk("op1", bus.op1_o, e.op1);
                    chk("op2", bus.op2_o, e.op2);
                    chk("store_data", bus.store_data_o, e.sd);
                end
`ifdef ID_EX_BUBBLE_CNT_EN
                chk("bubble_cnt", bus.bubble_cnt_o, e.cnt);
`endif
            end
        end
    end

    initial begin
        stim_t s, id;
        ex_m  = bubble();
        cnt_m = 32'd0;
        s = idle();
        bus.stall_i = 1'b0;  bus.flush_i = 1'b0;  bus.valid_i = 1'b1;
        bus.pc_i = '0;  bus.rs1_data_i = '0;  bus.rs2_data_i = '0;  bus.imm_i = '0;
        bus.rs1_addr_i = '0;  bus.rs2_addr_i = '0;  bus.rd_addr_i = 5'd9;
        bus.alu_op_i = 4'd3;  bus.op1_sel_i = '0;  bus.op2_sel_i = 1'b0;
        bus.reg_write_i = 1'b1;  bus.mem_read_i = 1'b0;  bus.mem_write_i = 1'b0;
        bus.exmem_rd_i = '0;  bus.exmem_reg_write_i = 1'b0;  bus.exmem_result_i = '0;
        bus.memwb_rd_i = '0;  bus.memwb_reg_write_i = 1'b0;  bus.memwb_result_i = '0;

        // Reset held with a valid instruction presented.
        s.rst = 1'b1;  s.valid = 1'b1;  s.rd = 5'd9;  s.alu_op = 4'd3;  s.rw = 1'b1;
        step(s);  step(s);

        // EX/MEM forward of rs1.
        s = idle();  s.valid = 1'b1;  s.rs1 = 5'd5;  s.rs2 = 5'd6;  s.rs1d = 32'd1;  s.rs2d = 32'd2;
        s.rd = 5'd10;  s.rw = 1'b1;
        step(s);
        s = idle();  s.em_rd = 5'd5;  s.em_we = 1'b1;  s.em_res = 32'h100;
        step(s);

        // EX/MEM beats MEM/WB; x0 never forwarded.
        s = idle();  s.valid = 1'b1;  s.rs1 = 5'd7;  s.rs1d = 32'h77;  s.rd = 5'd1;  s.rw = 1'b1;
        step(s);
        s = idle();  s.em_rd = 5'd7;  s.em_we = 1'b1;  s.em_res = 32'hAA;
        s.mw_rd = 5'd7;  s.mw_we = 1'b1;  s.mw_res = 32'hBB;
        step(s);
        s = idle();  s.valid = 1'b1;  s.rs1 = 5'd0;  s.rs1d = 32'd0;  s.rd = 5'd2;  s.rw = 1'b1;
        step(s);
        s = idle();  s.em_rd = 5'd0;  s.em_we = 1'b1;  s.em_res = 32'hDEAD;
        step(s);

        // Load-use: LW x3 in EX, ADD x3 in ID, re-presented after the bubble.
        s = idle();  s.valid = 1'b1;  s.rs1 = 5'd2;  s.rd = 5'd3;  s.op2_sel = 1'b1;
        s.imm = 32'd8;  s.mr = 1'b1;  s.rw = 1'b1;
        step(s);
        s = idle();  s.valid = 1'b1;  s.rs1 = 5'd3;  s.rs2 = 5'd4;  s.rs1d = 32'h33;
        s.rs2d = 32'h44;  s.rd = 5'd8;  s.rw = 1'b1;
        step(s);  step(s);
        id = s;
        s = idle();  s.mw_rd = 5'd3;  s.mw_we = 1'b1;  s.mw_res = 32'h1234;
        step(s);

        // Stall three cycles while MEM/WB result changes, then stall+flush together.
        s = id;  s.rs1 = 5'd4;  s.rd = 5'd11;
        step(s);
        for (int k = 0; k < 3; k++) begin
            s = idle();  s.stall = 1'b1;  s.mw_rd = 5'd4;  s.mw_we = 1'b1;
            s.mw_res = 32'h5000 + 32'(k);
            step(s);
        end
        s = idle();  s.stall = 1'b1;  s.flush = 1'b1;  s.valid = 1'b1;  s.rw = 1'b1;  s.rd = 5'd6;
        step(s);

        // PC/immediate operand selection.
        s = idle();  s.valid = 1'b1;  s.op1_sel = 2'b01;  s.op2_sel = 1'b1;
        s.pc = 32'h1000;  s.imm = 32'h10;  s.rd = 5'd12;  s.rw = 1'b1;
        step(s);
        s = idle();  s.valid = 1'b1;  s.op1_sel = 2'b10;  s.rs1 = 5'd1;  s.rs1d = 32'hFF;  s.rd = 5'd13;
        step(s);

        // Four flushes after a counter reset.
        s = idle();  s.rst = 1'b1;
        step(s);
        for (int k = 0; k < 4; k++) begin
            s = idle();  s.flush = 1'b1;  s.valid = 1'b1;
            step(s);
        end
        s = idle();  s.valid = 1'b1;
        step(s);

        // Randomised traffic on a small register set to provoke hazards and forwarding.
        id = idle();
        for (int n = 0; n < 3000; n++) begin
            logic hold;
            hold = last_lu || s.stall;
            s = idle();
            if (hold) s = id;
            else begin
                s.valid   = ($urandom_range(0, 99) < 85);
                s.pc      = $urandom();  s.rs1d = $urandom();  s.rs2d = $urandom();  s.imm = $urandom();
                s.rs1     = 5'($urandom_range(0, 7));
                s.rs2     = 5'($urandom_range(0, 7));
                s.rd      = 5'($urandom_range(0, 7));
                s.alu_op  = 4'($urandom_range(0, 15));
                s.op1_sel = 2'($urandom_range(0, 3));
                s.op2_sel = 1'($urandom_range(0, 1));
                s.rw      = 1'($urandom_range(0, 1));
                s.mr      = ($urandom_range(0, 99) < 30);
                s.mw      = !s.mr && ($urandom_range(0, 99) < 20);
            end
            s.rst    = ($urandom_range(0, 999) < 5);
            s.stall  = ($urandom_range(0, 99) < 15);
            s.flush  = ($urandom_range(0, 99) < 8);
            s.em_rd  = 5'($urandom_range(0, 7));  s.em_we = 1'($urandom_range(0, 1));
            s.em_res = $urandom();
            s.mw_rd  = 5'($urandom_range(0, 7));  s.mw_we = 1'($urandom_range(0, 1));
            s.mw_res = $urandom();
            id = s;
            step(s);
        end

        @(negedge clk);
        #3;
        n_chk++;
        if (exq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
